// File: rtl/regfile_writeback.sv
// Write-back producer for the register file: merges ALU and load results through a small
// FIFO, drains one write per cycle, and exposes a pending scoreboard plus a bypass lookup.
module regfile_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_alu_valid,
  output logic                      o_alu_ready,
  input  logic [ADDR_W-1:0]         i_alu_addr,
  input  logic [DATA_W-1:0]         i_alu_data,
  input  logic                      i_mem_valid,
  output logic                      o_mem_ready,
  input  logic [ADDR_W-1:0]         i_mem_addr,
  input  logic [DATA_W-1:0]         i_mem_data,
  input  logic [1:0]                i_ld_size,
  input  logic                      i_ld_signed,
  input  logic [1:0]                i_ld_off,
  output logic                      o_reg_en,
  output logic [ADDR_W-1:0]         o_reg_aw,
  output logic [DATA_W-1:0]         o_reg_din,
  output logic [(2**ADDR_W)-1:0]    o_pending,
  input  logic [ADDR_W-1:0]         i_byp_addr,
  output logic                      o_byp_hit,
  output logic [DATA_W-1:0]         o_byp_data,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W:0]    w_sum;
  logic              w_mem_push;
  logic              w_alu_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_alu_slot;
  logic [PTR_W-1:0]  w_idx;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_ld;

  assign o_count     = r_count;
  assign o_mem_ready = (r_count < CNT_W'(DEPTH));
  // The same-cycle pop is deliberately not credited, so readiness depends only on occupancy.
  assign w_sum       = {1'b0, r_count} + (CNT_W+1)'(i_mem_valid & o_mem_ready);
  assign o_alu_ready = (w_sum < (CNT_W+1)'(DEPTH));

  assign w_mem_push = i_mem_valid & o_mem_ready & (i_mem_addr != '0);
  assign w_alu_push = i_alu_valid & o_alu_ready & (i_alu_addr != '0);
  assign w_pop      = (r_count != '0);
  assign w_alu_slot = r_wptr + PTR_W'(w_mem_push);

  assign w_byte = i_mem_data[{i_ld_off, 3'b000} +: 8];
  assign w_half = i_mem_data[{i_ld_off[1], 4'b0000} +: 16];

  always_comb begin
    case (i_ld_size)
      2'b00:   w_ld = {{(DATA_W-8){i_ld_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ld = {{(DATA_W-16){i_ld_signed & w_half[15]}}, w_half};
      default: w_ld = i_mem_data;
    endcase
  end

  // Storage needs no reset; only the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_mem_push) begin
      r_addr[r_wptr] <= i_mem_addr;
      r_data[r_wptr] <= w_ld;
    end
    if (w_alu_push) begin
      r_addr[w_alu_slot] <= i_alu_addr;
      r_data[w_alu_slot] <= i_alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      o_reg_en  <= 1'b0;
      o_reg_aw  <= '0;
      o_reg_din <= '0;
    end else begin
      r_wptr  <= r_wptr + PTR_W'(w_mem_push) + PTR_W'(w_alu_push);
      r_rptr  <= r_rptr + PTR_W'(w_pop);
      r_count <= r_count + CNT_W'(w_mem_push) + CNT_W'(w_alu_push) - CNT_W'(w_pop);
      if (w_pop) begin
        o_reg_en  <= 1'b1;
        o_reg_aw  <= r_addr[r_rptr];
        o_reg_din <= r_data[r_rptr];
      end else begin
        o_reg_en  <= 1'b0;
      end
    end
  end

  // Scan oldest to youngest so the last match (the youngest write) wins.
  always_comb begin
    o_pending  = '0;
    o_byp_hit  = 1'b0;
    o_byp_data = '0;
    w_idx      = '0;
    if (o_reg_en) begin
      o_pending[o_reg_aw] = 1'b1;
      if (o_reg_aw == i_byp_addr) begin
        o_byp_hit  = 1'b1;
        o_byp_data = o_reg_din;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PTR_W'(i);
      if (CNT_W'(i) < r_count) begin
        o_pending[r_addr[w_idx]] = 1'b1;
        if (r_addr[w_idx] == i_byp_addr) begin
          o_byp_hit  = 1'b1;
          o_byp_data = r_data[w_idx];
        end
      end
    end
    if (i_byp_addr == '0) begin
      o_byp_hit  = 1'b0;
      o_byp_data = '0;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: load-format table, ordering, fill/wrap
// scoreboard, r0 drop and asynchronous reset while draining.
module tb_regfile_writeback;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr, byp_addr, reg_aw;
  logic [31:0] alu_data, mem_data, reg_din, byp_data, pending;
  logic [1:0]  ld_size, ld_off;
  logic        ld_signed, reg_en, byp_hit;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  ld_vec_t vecs [10];
  wr_t     expq [$];
  wr_t     item;

  regfile_writeback #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_addr(alu_addr), .i_alu_data(alu_data),
    .i_mem_valid(mem_valid), .o_mem_ready(mem_ready), .i_mem_addr(mem_addr), .i_mem_data(mem_data),
    .i_ld_size(ld_size), .i_ld_signed(ld_signed), .i_ld_off(ld_off),
    .o_reg_en(reg_en), .o_reg_aw(reg_aw), .o_reg_din(reg_din), .o_pending(pending),
    .i_byp_addr(byp_addr), .o_byp_hit(byp_hit), .o_byp_data(byp_data), .o_count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                               input logic av, input logic [4:0] aa, input logic [31:0] ad);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
  endtask

  function automatic wr_t mkItem(input int k);
    wr_t w;
    w.a = 5'(k + 1);
    w.d = 32'h100 + 32'(k);
    return w;
  endfunction

  initial begin
    int k, mcount, npop, cyc;
    logic mr, ar, macc, aacc, pop;
    wr_t mi, ai;

    vecs[0] = '{2'b00, 1'b1, 2'd3, 32'hFFFFFF80};
    vecs[1] = '{2'b00, 1'b0, 2'd1, 32'h0000007F};
    vecs[2] = '{2'b01, 1'b1, 2'd2, 32'hFFFF80FF};
    vecs[3] = '{2'b10, 1'b0, 2'd0, 32'h80FF7F01};
    vecs[4] = '{2'b11, 1'b1, 2'd2, 32'h80FF7F01};
    vecs[5] = '{2'b00, 1'b1, 2'd2, 32'hFFFFFFFF};
    vecs[6] = '{2'b00, 1'b0, 2'd2, 32'h000000FF};
    vecs[7] = '{2'b01, 1'b0, 2'd3, 32'h000080FF};
    vecs[8] = '{2'b01, 1'b1, 2'd1, 32'h00007F01};
    vecs[9] = '{2'b00, 1'b1, 2'd0, 32'h00000001};

    rst_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    ld_size = 2'b10; ld_signed = 1'b0; ld_off = 2'd0; byp_addr = 5'd5;
    #1 rst_n = 1'b0;
    #10;
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset reg_en", 32'(reg_en), 32'd0);
    checkOutput("reset reg_aw", 32'(reg_aw), 32'd0);
    checkOutput("reset reg_din", reg_din, 32'd0);
    checkOutput("reset pending", pending, 32'd0);
    checkOutput("reset byp_hit", 32'(byp_hit), 32'd0);
    rst_n = 1'b1;

    // Single ALU write r5
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("t1 count after push", 32'(count), 32'd1);
    checkOutput("t1 reg_en before pop", 32'(reg_en), 32'd0);
    checkOutput("t1 pending5 queued", 32'(pending[5]), 32'd1);
    checkOutput("t1 byp data queued", byp_data, 32'h1234);
    step();
    checkOutput("t1 reg_en", 32'(reg_en), 32'd1);
    checkOutput("t1 reg_aw", 32'(reg_aw), 32'd5);
    checkOutput("t1 reg_din", reg_din, 32'h1234);
    checkOutput("t1 pending5 output", 32'(pending[5]), 32'd1);
    checkOutput("t1 count drained", 32'(count), 32'd0);
    step();
    checkOutput("t1 reg_en low", 32'(reg_en), 32'd0);
    checkOutput("t1 pending clear", pending, 32'd0);
    checkOutput("t1 reg_din hold", reg_din, 32'h1234);
    checkOutput("t1 byp miss data", byp_data, 32'd0);

    // Load formatting table
    for (int i = 0; i < 10; i++) begin
      ld_size = vecs[i].size; ld_signed = vecs[i].sgn; ld_off = vecs[i].off;
      applyStimulus(1'b1, 5'd7, 32'h80FF7F01, 1'b0, 5'd0, 32'd0);
      step();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      step();
      checkOutput($sformatf("load%0d reg_en", i), 32'(reg_en), 32'd1);
      checkOutput($sformatf("load%0d reg_din", i), reg_din, vecs[i].exp);
    end
    step();
    ld_size = 2'b10; ld_signed = 1'b0; ld_off = 2'd0;

    // Both sources in one cycle to r3: mem older than ALU
    applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
    byp_addr = 5'd3;
    #1;
    checkOutput("t3 mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("t3 alu_ready", 32'(alu_ready), 32'd1);
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("t3 count", 32'(count), 32'd2);
    checkOutput("t3 byp hit queued", 32'(byp_hit), 32'd1);
    checkOutput("t3 byp youngest", byp_data, 32'hB);
    step();
    checkOutput("t3 first din", reg_din, 32'hA);
    checkOutput("t3 byp youngest 2", byp_data, 32'hB);
    step();
    checkOutput("t3 second en", 32'(reg_en), 32'd1);
    checkOutput("t3 second din", reg_din, 32'hB);
    checkOutput("t3 byp from output", byp_data, 32'hB);
    step();
    checkOutput("t3 byp hit gone", 32'(byp_hit), 32'd0);

    // Fill with drain running: 12 writes, scoreboarded across pointer wrap
    k = 0; mcount = 0; npop = 0; cyc = 0;
    while ((k < 12 || mcount > 0) && cyc < 60) begin
      mi = mkItem(k);
      ai = mkItem(k + 1);
      applyStimulus(k < 12, mi.a, mi.d, (k + 1) < 12, ai.a, ai.d);
      #1;
      mr = (mcount < 4);
      ar = ((mcount + ((mem_valid && mr) ? 1 : 0)) < 4);
      checkOutput("fill mem_ready", 32'(mem_ready), 32'(mr));
      checkOutput("fill alu_ready", 32'(alu_ready), 32'(ar));
      macc = mem_valid && mr;
      aacc = alu_valid && ar;
      if (macc) expq.push_back(mi);
      if (aacc) expq.push_back(ai);
      k = k + (macc ? 1 : 0) + (aacc ? 1 : 0);
      pop = (mcount > 0);
      mcount = mcount + (macc ? 1 : 0) + (aacc ? 1 : 0) - (pop ? 1 : 0);
      step();
      checkOutput("fill reg_en", 32'(reg_en), 32'(pop));
      if (pop) begin
        item = expq.pop_front();
        npop++;
        checkOutput("fill reg_aw", 32'(reg_aw), 32'(item.a));
        checkOutput("fill reg_din", reg_din, item.d);
      end
      checkOutput("fill count", 32'(count), 32'(mcount));
      cyc++;
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("fill all accepted", 32'(k), 32'd12);
    checkOutput("fill all written", 32'(npop), 32'd12);
    step();

    // ALU write to r0 is accepted and dropped
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    byp_addr = 5'd0;
    #1;
    checkOutput("r0 alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("r0 byp_hit", 32'(byp_hit), 32'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    checkOutput("r0 count", 32'(count), 32'd0);
    checkOutput("r0 pending", pending, 32'd0);
    step();
    checkOutput("r0 reg_en", 32'(reg_en), 32'd0);
    checkOutput("r0 byp_hit after", 32'(byp_hit), 32'd0);

    // Async reset with three queued entries and a write on the output
    applyStimulus(1'b1, 5'd9, 32'h900, 1'b1, 5'd10, 32'hA00);
    step();
    applyStimulus(1'b1, 5'd11, 32'hB00, 1'b1, 5'd12, 32'hC00);
    step();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    byp_addr = 5'd12;
    #1;
    checkOutput("rst pre count", 32'(count), 32'd3);
    checkOutput("rst pre reg_en", 32'(reg_en), 32'd1);
    checkOutput("rst pre byp", byp_data, 32'hC00);
    rst_n = 1'b0;
    #1;
    checkOutput("rst reg_en", 32'(reg_en), 32'd0);
    checkOutput("rst reg_aw", 32'(reg_aw), 32'd0);
    checkOutput("rst reg_din", reg_din, 32'd0);
    checkOutput("rst count", 32'(count), 32'd0);
    checkOutput("rst pending", pending, 32'd0);
    checkOutput("rst byp_hit", 32'(byp_hit), 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("post-rst reg_en", 32'(reg_en), 32'd0);
      checkOutput("post-rst count", 32'(count), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
